// File: rtl/display_scanner.sv
// -----------------------------------------------------------------------------
// display_scanner
//
// Time-multiplexed 7-segment scan controller for the MK14 display/keypad page.
// Walks the MMU display read port one digit at a time, latches the returned
// segment pattern and lights the matching digit for a fixed dwell time,
// followed by an all-off blanking gap. One frame covers digits 0..DIGITS-1.
//
// Parameters
//   CLOCK_FREQ_MHZ  clock ticks per microsecond
//   DIGITS          digits scanned per frame (1..8)
//   DIGIT_US        on-time per digit in us (0 behaves as one clock)
//   BLANK_US        all-off gap after each digit in us (0 behaves as one clock)
//
// Ports
//   clk              in   system clock
//   rst              in   synchronous, active-high reset
//   enable           in   1 = scan frames, 0 = stop at the next digit boundary
//   display_read_en  out  one-cycle read strobe to the MMU display port
//   display_addr     out  digit index being read, zero-extended to 16 bits
//   display_data     in   MMU display data, valid one cycle after the strobe
//   seg              out  segment pattern {dp,g..a}, active-high
//   dig_sel          out  one-hot digit enable, active-high
//   frame_done       out  one-cycle pulse on the last blank cycle of a frame
//
// Every output is a register. The output logic computes the value each
// output must show in the *next* state, so outputs change on the same edge
// as the state they belong to.
// -----------------------------------------------------------------------------
module display_scanner #(
    parameter int CLOCK_FREQ_MHZ = 50,
    parameter int DIGITS         = 8,
    parameter int DIGIT_US       = 1000,
    parameter int BLANK_US       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              display_read_en,
    output logic [15:0]       display_addr,
    input  logic [7:0]        display_data,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] dig_sel,
    output logic              frame_done
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int SHOW_RAW    = DIGIT_US * CLOCK_FREQ_MHZ;
    localparam int BLANK_RAW   = BLANK_US * CLOCK_FREQ_MHZ;
    // A zero-length period still occupies one clock.
    localparam int SHOW_TICKS  = (SHOW_RAW  > 0) ? SHOW_RAW  : 1;
    localparam int BLANK_TICKS = (BLANK_RAW > 0) ? BLANK_RAW : 1;

    localparam int MAX_US      = (DIGIT_US > BLANK_US) ? DIGIT_US : BLANK_US;
    localparam int TIMER_W_RAW = $clog2(MAX_US * CLOCK_FREQ_MHZ + 1);
    localparam int TIMER_W     = (TIMER_W_RAW < 1) ? 1 : TIMER_W_RAW;

    localparam int DIGIT_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // The timer counts down to zero inclusive, so a period of N clocks
    // loads N-1.
    localparam logic [TIMER_W-1:0] SHOW_LOAD  = TIMER_W'(SHOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] BLANK_LOAD = TIMER_W'(BLANK_TICKS - 1);
    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(DIGITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_CAP   = 3'd2,
        ST_SHOW  = 3'd3,
        ST_BLANK = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t              state_q,   state_d;
    logic [DIGIT_W-1:0]  digit_q,   digit_d;
    logic [TIMER_W-1:0]  timer_q,   timer_d;

    logic                read_en_q, read_en_d;
    logic [15:0]         addr_q,    addr_d;
    logic [7:0]          seg_q,     seg_d;
    logic [DIGITS-1:0]   sel_q,     sel_d;
    logic                frame_q,   frame_d;

    // One-hot decode of the current digit index.
    logic [DIGITS-1:0]   digit_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_onehot
            assign digit_onehot[gi] = (digit_q == DIGIT_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Process 1: state register (plus registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            digit_q   <= '0;
            timer_q   <= '0;
            read_en_q <= 1'b0;
            addr_q    <= '0;
            seg_q     <= '0;
            sel_q     <= '0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            timer_q   <= timer_d;
            read_en_q <= read_en_d;
            addr_q    <= addr_d;
            seg_q     <= seg_d;
            sel_q     <= sel_d;
            frame_q   <= frame_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        timer_d = timer_q;

        unique case (state_q)
            ST_IDLE: begin
                // Scanning always restarts from the first digit.
                if (enable) begin
                    state_d = ST_REQ;
                    digit_d = '0;
                end
            end

            ST_REQ: begin
                state_d = ST_CAP;
            end

            ST_CAP: begin
                state_d = ST_SHOW;
                timer_d = SHOW_LOAD;
            end

            ST_SHOW: begin
                if (timer_q == '0) begin
                    state_d = ST_BLANK;
                    timer_d = BLANK_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_BLANK: begin
                if (timer_q == '0) begin
                    // The digit advances even when scanning stops here;
                    // enable is only looked at on this final blank cycle.
                    if (digit_q == LAST_DIGIT) begin
                        digit_d = '0;
                    end else begin
                        digit_d = digit_q + 1'b1;
                    end
                    state_d = enable ? ST_REQ : ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                digit_d = '0;
                timer_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: output logic (values for the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        read_en_d = 1'b0;
        addr_d    = '0;
        seg_d     = '0;
        sel_d     = '0;
        frame_d   = 1'b0;

        // Exactly one strobe per visit: REQ never follows REQ, so the
        // strobe is a single cycle by construction.
        if (state_d == ST_REQ) begin
            read_en_d = 1'b1;
            addr_d    = 16'(digit_d);
        end

        // MMU data is valid during CAP (one cycle after the strobe); latch
        // it together with the digit enable so segments and digit light up
        // on the same edge. Hold them through SHOW, drop them on leaving.
        if (state_q == ST_CAP) begin
            seg_d = display_data;
            sel_d = digit_onehot;
        end else if (state_q == ST_SHOW && state_d == ST_SHOW) begin
            seg_d = seg_q;
            sel_d = sel_q;
        end

        // Pulse during the final blank cycle of the last digit.
        if (state_d == ST_BLANK && timer_d == '0 && digit_d == LAST_DIGIT) begin
            frame_d = 1'b1;
        end
    end

    assign display_read_en = read_en_q;
    assign display_addr    = addr_q;
    assign seg             = seg_q;
    assign dig_sel         = sel_q;
    assign frame_done      = frame_q;

endmodule

// File: tb/tb_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_display_scanner
//
// Self-checking bench for display_scanner with CLOCK_FREQ_MHZ=2, DIGIT_US=3,
// BLANK_US=1, DIGITS=8 (10 cycles per digit, 80-cycle frame). A small MMU
// model answers the read strobes; a reference model describes each digit
// visit as a position 0..9 inside a 10-cycle slot.
// -----------------------------------------------------------------------------
module tb_display_scanner;

    localparam int F       = 2;
    localparam int DU      = 3;
    localparam int BU      = 1;
    localparam int ND      = 8;
    localparam int SHOW_C  = F * DU;
    localparam int BLANK_C = F * BU;
    localparam int PER     = 2 + SHOW_C + BLANK_C;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          enable = 1'b0;
    logic          rd;
    logic [15:0]   addr;
    logic [7:0]    data   = 8'h00;
    logic [7:0]    seg;
    logic [ND-1:0] sel;
    logic          fd;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;
    bit prev_rd = 1'b0;

    always #5 clk = ~clk;

    display_scanner #(
        .CLOCK_FREQ_MHZ(F),
        .DIGITS        (ND),
        .DIGIT_US      (DU),
        .BLANK_US      (BU)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .display_read_en(rd),
        .display_addr   (addr),
        .display_data   (data),
        .seg            (seg),
        .dig_sel        (sel),
        .frame_done     (fd)
    );

    // ------------------------------------------------------------------
    // MMU display port model. mode 0: 8'h10+addr; mode 1: every digit holds
    // 8'h3F with a 1-bit auto-dim counter per digit (odd reads show the
    // value, even reads show 0); mode 2: random contents.
    // ------------------------------------------------------------------
    int         mode    = 0;
    bit         mmu_clr = 1'b0;
    logic [7:0] rmem   [ND];
    bit         dimmed [ND];

    always @(posedge clk) begin
        if (mmu_clr) begin
            for (int i = 0; i < ND; i++) dimmed[i] <= 1'b0;
            data <= 8'h00;
        end else if (rd) begin
            case (mode)
                0: data <= 8'h10 + addr[7:0];
                1: begin
                    data <= dimmed[addr[2:0]] ? 8'h00 : 8'h3F;
                    dimmed[addr[2:0]] <= ~dimmed[addr[2:0]];
                end
                default: data <= rmem[addr[2:0]];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Reference model: scanning is either idle or inside a digit slot at
    // position m_pos (0 = strobe, 2..7 = lit, 8..9 = blank).
    // ------------------------------------------------------------------
    bit m_active = 1'b0;
    int m_pos    = 0;
    int m_dig    = 0;
    int m_visits [ND];

    always @(posedge clk) begin
        if (mmu_clr) begin
            for (int i = 0; i < ND; i++) m_visits[i] <= 0;
        end
        if (rst) begin
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (enable) begin
                m_active    <= 1'b1;
                m_pos       <= 0;
                m_dig       <= 0;
                m_visits[0] <= m_visits[0] + 1;
            end
        end else if (m_pos == PER - 1) begin
            m_dig <= (m_dig + 1) % ND;
            if (enable) begin
                m_pos <= 0;
                m_visits[(m_dig + 1) % ND] <= m_visits[(m_dig + 1) % ND] + 1;
            end else begin
                m_active <= 1'b0;
            end
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    function automatic logic [7:0] exp_data(int d);
        case (mode)
            0:       return 8'h10 + 8'(d);
            1:       return (m_visits[d] % 2 == 1) ? 8'h3F : 8'h00;
            default: return rmem[d];
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance to the next negedge and run the every-cycle checks.
    task automatic tick();
        logic          lit;
        logic          e_rd;
        logic [15:0]   e_addr;
        logic [7:0]    e_seg;
        logic [ND-1:0] e_sel;
        logic          e_fd;
        @(negedge clk);
        cyc++;
        if (chk_on) begin
            lit    = m_active && m_pos >= 2 && m_pos < 2 + SHOW_C;
            e_rd   = m_active && m_pos == 0;
            e_addr = e_rd ? 16'(m_dig) : 16'h0;
            e_seg  = lit ? exp_data(m_dig) : 8'h00;
            e_sel  = lit ? (ND'(1) << m_dig) : '0;
            e_fd   = m_active && m_pos == PER - 1 && m_dig == ND - 1;
            check("model", 64'({rd, addr, seg, sel, fd}),
                  64'({e_rd, e_addr, e_seg, e_sel, e_fd}));
            check("onehot0", 64'($onehot0(sel)), 64'(1));
            if (sel == '0) check("seg_dark", 64'(seg), 64'(0));
            if (prev_rd) check("strobe_gap", 64'(rd), 64'(0));
            prev_rd = rd;
        end
    endtask

    task automatic do_reset(int m, bit en);
        rst     = 1'b1;
        enable  = en;
        mode    = m;
        mmu_clr = 1'b1;
        if (m == 2) begin
            for (int i = 0; i < ND; i++) rmem[i] = 8'($urandom);
        end
        tick();
        tick();
        mmu_clr = 1'b0;
        rst     = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Table for reset release and enable drop (cycle numbers from the
    // first strobe). en is the enable value driven from that cycle on.
    // ------------------------------------------------------------------
    typedef struct {
        int          cyc;
        logic        en;
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  seg;
        logic [7:0]  sel;
        logic        fd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(int c, logic en, logic r, logic [15:0] a,
                                logic [7:0] s, logic [7:0] d, logic f);
        vec_t v;
        v.cyc = c; v.en = en; v.rd = r; v.addr = a;
        v.seg = s; v.sel = d; v.fd = f;
        return v;
    endfunction

    int strobes;
    int fds;
    int fd_cyc;
    int k;

    initial begin
        vq.push_back(mk( 0, 1'b1, 1'b1, 16'd0, 8'h00, 8'h00, 1'b0));
        vq.push_back(mk( 1, 1'b1, 1'b0, 16'd0, 8'h00, 8'h00, 1'b0));
        vq.push_back(mk( 2, 1'b1, 1'b0, 16'd0, 8'h10, 8'h01, 1'b0));
        vq.push_back(mk( 7, 1'b1, 1'b0, 16'd0, 8'h10, 8'h01, 1'b0));
        vq.push_back(mk( 8, 1'b1, 1'b0, 16'd0, 8'h00, 8'h00, 1'b0));
        vq.push_back(mk( 9, 1'b1, 1'b0, 16'd0, 8'h00, 8'h00, 1'b0));
        vq.push_back(mk(10, 1'b1, 1'b1, 16'd1, 8'h00, 8'h00, 1'b0));
        vq.push_back(mk(11, 1'b1, 1'b0, 16'd0, 8'h00, 8'h00, 1'b0));
        vq.push_back(mk(12, 1'b1, 1'b0, 16'd0, 8'h11, 8'h02, 1'b0));
        vq.push_back(mk(13, 1'b0, 1'b0, 16'd0, 8'h11, 8'h02, 1'b0));
        vq.push_back(mk(17, 1'b0, 1'b0, 16'd0, 8'h11, 8'h02, 1'b0));
        vq.push_back(mk(18, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00, 1'b0));
        vq.push_back(mk(19, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00, 1'b0));
        vq.push_back(mk(20, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00, 1'b0));
        vq.push_back(mk(25, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00, 1'b0));
        vq.push_back(mk(29, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00, 1'b0));

        // Power-up reset, then start checking every cycle.
        rst = 1'b1;
        tick();
        chk_on = 1'b1;
        check("reset_state", 64'({rd, addr, seg, sel, fd}), 64'(0));

        // Reset release with enable high; enable dropped during digit 1.
        do_reset(0, 1'b1);
        k = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (k < vq.size() && vq[k].cyc == c) begin
                enable = vq[k].en;
                check($sformatf("table_c%0d", c), 64'({rd, addr, seg, sel, fd}),
                      64'({vq[k].rd, vq[k].addr, vq[k].seg, vq[k].sel, vq[k].fd}));
                k++;
            end
        end
        enable = 1'b1;
        tick();
        check("reenable_rd", 64'(rd), 64'(1));
        check("reenable_addr", 64'(addr), 64'(0));

        // Full frame.
        do_reset(0, 1'b1);
        strobes = 0; fds = 0; fd_cyc = -1;
        for (int c = 0; c < ND * PER; c++) begin
            tick();
            if (rd) begin
                check($sformatf("frame_addr%0d", strobes), 64'(addr), 64'(strobes));
                strobes++;
            end
            if (fd) begin
                fds++;
                fd_cyc = c;
            end
        end
        check("frame_strobes", 64'(strobes), 64'(ND));
        check("frame_done_count", 64'(fds), 64'(1));
        check("frame_done_cycle", 64'(fd_cyc), 64'(ND * PER - 1));
        tick();
        check("wrap_rd", 64'(rd), 64'(1));
        check("wrap_addr", 64'(addr), 64'(0));

        // Auto-dim MMU: frame 1 shows 3F, frame 2 shows 00, 16 reads total.
        do_reset(1, 1'b1);
        strobes = 0;
        for (int c = 0; c < 2 * ND * PER; c++) begin
            tick();
            if (rd) strobes++;
            if (c % PER == 4) begin
                check($sformatf("dim_seg_f%0d_d%0d", c / (ND * PER), (c % (ND * PER)) / PER),
                      64'(seg), (c < ND * PER) ? 64'(8'h3F) : 64'(8'h00));
                check($sformatf("dim_sel_d%0d", (c % (ND * PER)) / PER),
                      64'(sel), 64'(8'h01 << ((c % (ND * PER)) / PER)));
            end
        end
        check("dim_reads", 64'(strobes), 64'(2 * ND));

        // Reset during SHOW of digit 5.
        do_reset(0, 1'b1);
        for (int c = 0; c <= 5 * PER + 3; c++) tick();
        check("pre_rst_sel", 64'(sel), 64'(8'h20));
        check("pre_rst_seg", 64'(seg), 64'(8'h15));
        rst = 1'b1;
        tick();
        check("rst_outputs", 64'({rd, addr, seg, sel, fd}), 64'(0));
        rst = 1'b0;
        strobes = 0;
        for (int c = 0; c < PER; c++) begin
            tick();
            if (c == 0) begin
                check("post_rst_rd", 64'(rd), 64'(1));
                check("post_rst_addr", 64'(addr), 64'(0));
            end
            if (rd) strobes++;
        end
        check("post_rst_strobes", 64'(strobes), 64'(1));

        // Randomized enable toggling and reset pulses against the model.
        do_reset(2, 1'b1);
        for (int c = 0; c < 2000; c++) begin
            tick();
            if ($urandom_range(0, 24) == 0) enable = ~enable;
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
